// File: rtl/hydra_router.sv
// hydra_router: round-robin N-port Hydra packet router with config tap,
// odd-parity shared TX bus and saturating drop counter.
module hydra_router #(
   parameter int         WIDTH          = 64,
   parameter int         NUM_PORTS      = 4,
   parameter logic [7:0] GLOBAL_ID      = 8'hFF,
   parameter int         TIMEOUT_CYCLES = 255,
   parameter int         DROP_BITS      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [7:0]                     chip_id,
   input  logic [NUM_PORTS-1:0]           enable_posi,
   input  logic [NUM_PORTS-1:0]           enable_piso_upstream,
   input  logic [NUM_PORTS-1:0]           enable_piso_downstream,
   input  logic [NUM_PORTS-1:0]           rx_valid,
   input  logic [NUM_PORTS*(WIDTH-1)-1:0] rx_data,
   output logic [NUM_PORTS-1:0]           rx_ack,
   input  logic                           local_valid,
   input  logic [WIDTH-2:0]               local_data,
   output logic                           local_ack,
   output logic                           cfg_valid,
   output logic [WIDTH-2:0]               cfg_data,
   input  logic                           cfg_ready,
   input  logic [NUM_PORTS-1:0]           tx_busy,
   output logic [NUM_PORTS-1:0]           tx_load,
   output logic [WIDTH-1:0]               tx_data,
   input  logic                           fifo_full,
   input  logic                           fifo_half,
   output logic [DROP_BITS-1:0]           drop_count
);

   localparam int PW = WIDTH - 1;
   localparam int NS = NUM_PORTS + 1;
   localparam int SW = $clog2(NS);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, ISSUE, DROP} state_t;

   state_t state, state_nx;

   logic [SW-1:0]        rr_ptr;
   logic [SW-1:0]        src;
   logic [PW-1:0]        pkt;
   logic [NUM_PORTS-1:0] dest;
   logic                 cfg_hit;
   logic [TW-1:0]        wait_cnt;

   logic [NS-1:0]        req;
   logic [2*NS-1:0]      req_rot;
   logic                 grant_ok;
   logic [SW-1:0]        grant;
   logic [PW-1:0]        sel_pkt;
   logic [NUM_PORTS-1:0] self_mask;
   logic [1:0]           typ;
   logic [7:0]           id;
   logic [PW-1:0]        pkt_nx;
   logic [NUM_PORTS-1:0] dest_nx;
   logic                 cfg_nx;
   logic                 go;
   logic                 expire;
   logic                 ack_pulse;

   assign req     = {local_valid, rx_valid & enable_posi};
   assign req_rot = {req, req} >> rr_ptr;

   always_comb begin
      grant_ok = 1'b0;
      grant    = '0;
      for (int k = 0; k < NS; k++) begin
         if (!grant_ok && req_rot[k]) begin
            grant_ok = 1'b1;
            grant    = SW'((int'(rr_ptr) + k) % NS);
         end
      end
   end

   always_comb begin
      sel_pkt   = local_data;
      self_mask = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant == SW'(p)) begin
            sel_pkt      = rx_data[p*PW +: PW];
            self_mask[p] = 1'b1;
         end
      end
   end

   assign typ = sel_pkt[1:0];
   assign id  = sel_pkt[9:2];

   // Local config-read replies addressed to us carry live FIFO status.
   always_comb begin
      pkt_nx  = sel_pkt;
      cfg_nx  = 1'b0;
      dest_nx = enable_piso_upstream;
      if (grant == SW'(NUM_PORTS)) begin
         if (typ == 2'b11 && id == chip_id)
            pkt_nx[PW-2 -: 2] = {fifo_full, fifo_half};
      end else if (typ[1]) begin
         if (id == chip_id) begin
            cfg_nx  = 1'b1;
            dest_nx = '0;
         end else begin
            cfg_nx  = (id == GLOBAL_ID);
            dest_nx = enable_piso_downstream & ~self_mask;
         end
      end else begin
         dest_nx = enable_piso_upstream & ~self_mask;
      end
   end

   assign go     = ((dest & tx_busy) == '0) && (!cfg_hit || cfg_ready);
   assign expire = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      tx_load   = '0;
      cfg_valid = 1'b0;
      ack_pulse = 1'b0;
      unique case (state)
         IDLE: if (grant_ok) state_nx = WAIT;
         WAIT: begin
            if (dest == '0 && !cfg_hit) state_nx = DROP;
            else if (go)                state_nx = ISSUE;
            else if (expire)            state_nx = DROP;
         end
         ISSUE: begin
            tx_load   = dest;
            cfg_valid = cfg_hit;
            ack_pulse = 1'b1;
            state_nx  = IDLE;
         end
         DROP: begin
            ack_pulse = 1'b1;
            state_nx  = IDLE;
         end
      endcase
   end

   always_comb begin
      rx_ack    = '0;
      local_ack = ack_pulse && (src == SW'(NUM_PORTS));
      for (int p = 0; p < NUM_PORTS; p++)
         rx_ack[p] = ack_pulse && (src == SW'(p));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr     <= '0;
         src        <= '0;
         pkt        <= '0;
         dest       <= '0;
         cfg_hit    <= 1'b0;
         wait_cnt   <= '0;
         tx_data    <= '0;
         cfg_data   <= '0;
         drop_count <= '0;
      end else begin
         if (state == IDLE && grant_ok) begin
            src      <= grant;
            pkt      <= pkt_nx;
            dest     <= dest_nx;
            cfg_hit  <= cfg_nx;
            wait_cnt <= '0;
            rr_ptr   <= (grant == SW'(NUM_PORTS)) ? '0 : grant + 1'b1;
         end
         if (state == WAIT)
            wait_cnt <= wait_cnt + 1'b1;
         // Outputs are registered on entry to ISSUE so the bus holds afterwards.
         if (state == WAIT && state_nx == ISSUE) begin
            tx_data  <= {~^pkt, pkt};
            cfg_data <= pkt;
         end
         if (state == DROP && drop_count != '1)
            drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hydra_router.sv
// tb_hydra_router: directed and randomized transactions checked against
// a rule-level model of arbitration, routing, timeout and drop counting.
`timescale 1ns/1ps
module tb_hydra_router;

   localparam int         W  = 64;
   localparam int         N  = 4;
   localparam int         PW = W - 1;
   localparam int         NS = N + 1;
   localparam int         TO = 8;
   localparam int         DB = 4;
   localparam logic [7:0] GID = 8'hFF;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    chip_id;
   logic [N-1:0]  enable_posi, enable_piso_upstream, enable_piso_downstream;
   logic [N-1:0]  rx_valid, rx_ack, tx_busy, tx_load;
   logic [N*PW-1:0] rx_data;
   logic          local_valid, local_ack, cfg_valid, cfg_ready;
   logic          fifo_full, fifo_half;
   logic [PW-1:0] local_data, cfg_data;
   logic [W-1:0]  tx_data;
   logic [DB-1:0] drop_count;

   always #5 clk = ~clk;

   hydra_router #(
      .WIDTH(W), .NUM_PORTS(N), .GLOBAL_ID(GID),
      .TIMEOUT_CYCLES(TO), .DROP_BITS(DB)
   ) dut (
      .clk(clk), .reset(reset), .chip_id(chip_id),
      .enable_posi(enable_posi),
      .enable_piso_upstream(enable_piso_upstream),
      .enable_piso_downstream(enable_piso_downstream),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
      .local_valid(local_valid), .local_data(local_data),
      .local_ack(local_ack),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .tx_busy(tx_busy), .tx_load(tx_load), .tx_data(tx_data),
      .fifo_full(fifo_full), .fifo_half(fifo_half),
      .drop_count(drop_count)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic          pend_v [NS];
   logic [PW-1:0] pend_d [NS];
   int            rr;
   int            drops;
   logic [W-1:0]  last_tx;
   logic          last_ok;
   int            rel_at;

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // A source may only withdraw valid in the cycle it is acked.
   logic [NS-1:0] v_q = '0;
   always @(posedge clk) begin
      if (!reset)
         assert ((v_q & ~{local_valid, rx_valid} & ~{local_ack, rx_ack}) == '0)
         else $error("source withdrew valid before ack");
      v_q <= {local_valid, rx_valid};
   end

   task automatic drive_src();
      for (int s = 0; s < N; s++) begin
         rx_valid[s]          = pend_v[s];
         rx_data[s*PW +: PW]  = pend_d[s];
      end
      local_valid = pend_v[N];
      local_data  = pend_d[N];
   endtask

   function automatic logic [PW-1:0] mk_pkt();
      logic [PW-1:0] p;
      int r;
      p = PW'({$urandom, $urandom});
      r = $urandom_range(0, 3);
      if (r == 0)      p[9:2] = chip_id;
      else if (r == 1) p[9:2] = GID;
      return p;
   endfunction

   function automatic void route(input int s, input logic [PW-1:0] p,
                                 output logic [N-1:0] d, output logic c,
                                 output logic [PW-1:0] q);
      int ty;
      logic [N-1:0] others;
      ty = int'(p[1:0]);
      q = p;
      c = 1'b0;
      others = '1;
      if (s < N) others[s] = 1'b0;
      if (s == N) begin
         d = enable_piso_upstream;
         if (ty == 3 && p[9:2] == chip_id) begin
            q[61] = fifo_full;
            q[60] = fifo_half;
         end
      end else if (ty >= 2) begin
         if (p[9:2] == chip_id) begin
            c = 1'b1;
            d = '0;
         end else begin
            c = (p[9:2] == GID);
            d = enable_piso_downstream & others;
         end
      end else begin
         d = enable_piso_upstream & others;
      end
   endfunction

   task automatic set_base();
      chip_id                = 8'h05;
      enable_posi            = '1;
      enable_piso_upstream   = '1;
      enable_piso_downstream = '1;
      tx_busy                = '0;
      cfg_ready              = 1'b1;
      fifo_full              = 1'b0;
      fifo_half              = 1'b0;
      rel_at                 = 0;
   endtask

   task automatic run_txn(input string tag, output int got_slot);
      int g, s, lat, lat_exp, exp_ack;
      logic [N-1:0] d;
      logic c, issue, seen;
      logic [PW-1:0] q;
      logic [W-1:0] exp_tx;
      got_slot = -1;
      drive_src();
      g = -1;
      for (int k = 0; k < NS; k++) begin
         s = (rr + k) % NS;
         if (g < 0 && pend_v[s] && (s == N || enable_posi[s])) g = s;
      end
      if (g < 0) begin
         repeat (3) begin
            @(negedge clk);
            chk({tag, "-idle"}, W'({rx_ack, local_ack, tx_load, cfg_valid}), '0);
         end
         return;
      end
      route(g, pend_d[g], d, c, q);
      if (d == '0 && !c) begin
         issue = 1'b0; lat_exp = 2;
      end else if ((d & tx_busy) == '0 && (!c || cfg_ready)) begin
         issue = 1'b1; lat_exp = 2;
      end else if (rel_at >= 1 && rel_at <= TO) begin
         issue = 1'b1; lat_exp = rel_at + 1;
      end else begin
         issue = 1'b0; lat_exp = TO + 1;
      end
      rr = (g + 1) % NS;
      exp_ack = (g < N) ? (1 << (g + 1)) : 1;
      exp_tx = {1'(($countones(q) % 2) == 0), q};

      @(posedge clk);
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < TO + 6) begin
         @(negedge clk);
         lat++;
         if (rx_ack != '0 || local_ack || tx_load != '0 || cfg_valid)
            seen = 1'b1;
         if (lat == 1) begin
            enable_posi            = N'($urandom);
            enable_piso_upstream   = N'($urandom);
            enable_piso_downstream = N'($urandom);
            fifo_full              = 1'($urandom);
            fifo_half              = 1'($urandom);
         end
         if (lat == rel_at) begin
            tx_busy   = '0;
            cfg_ready = 1'b1;
         end
      end
      chk({tag, "-seen"}, W'(seen), 1);
      chk({tag, "-lat"}, W'(lat), W'(lat_exp));
      chk({tag, "-ack"}, W'({rx_ack, local_ack}), W'(exp_ack));
      chk({tag, "-load"}, W'(tx_load), issue ? W'(d) : '0);
      chk({tag, "-cfgv"}, W'(cfg_valid), W'(issue && c));
      if (local_ack) got_slot = N;
      for (int p = 0; p < N; p++) if (rx_ack[p]) got_slot = p;
      if (issue && d != '0) begin
         chk({tag, "-txd"}, tx_data, exp_tx);
         last_tx = exp_tx;
         last_ok = 1'b1;
      end else if (issue) begin
         last_ok = 1'b0;
      end else if (last_ok) begin
         chk({tag, "-hold"}, tx_data, last_tx);
      end
      if (issue && c) chk({tag, "-cfgd"}, W'(cfg_data), W'(q));
      if (!issue && drops < (1 << DB) - 1) drops++;
      pend_v[g] = 1'b0;
      drive_src();
      @(negedge clk);
      chk({tag, "-drops"}, W'(drop_count), W'(drops));
      chk({tag, "-quiet"}, W'({rx_ack, local_ack, tx_load, cfg_valid}), '0);
   endtask

   task automatic randomize_stim();
      logic any;
      chip_id                = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h05;
      enable_posi            = N'($urandom) | N'($urandom);
      enable_piso_upstream   = N'($urandom);
      enable_piso_downstream = N'($urandom);
      tx_busy   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cfg_ready = ($urandom_range(0, 3) != 0);
      fifo_full = 1'($urandom);
      fifo_half = 1'($urandom);
      rel_at    = $urandom_range(0, 12);
      for (int s = 0; s < NS; s++)
         if (!pend_v[s] && $urandom_range(0, 1) == 1) begin
            pend_v[s] = 1'b1;
            pend_d[s] = mk_pkt();
         end
      any = pend_v[N];
      for (int s = 0; s < N; s++) any |= pend_v[s] && enable_posi[s];
      if (!any) begin
         pend_v[N] = 1'b1;
         pend_d[N] = mk_pkt();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int slot;
   int order [6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      for (int s = 0; s < NS; s++) begin
         pend_v[s] = 1'b0;
         pend_d[s] = '0;
      end
      rr = 0; drops = 0; last_tx = '0; last_ok = 1'b0;
      reset = 1'b1;
      set_base();
      drive_src();
      repeat (3) @(negedge clk);
      chk("rst-out", W'({rx_ack, local_ack, tx_load, cfg_valid}), '0);
      chk("rst-txd", tx_data, '0);
      chk("rst-cfgd", W'(cfg_data), '0);
      chk("rst-drops", W'(drop_count), '0);
      reset = 1'b0;
      @(negedge clk);

      set_base();
      run_txn("idle", slot);

      set_base();
      enable_piso_upstream = 4'b0001;
      pend_v[N] = 1'b1; pend_d[N] = PW'(64'h1234);
      run_txn("local_data", slot);

      set_base();
      fifo_half = 1'b1;
      pend_v[2] = 1'b1; pend_d[2] = PW'(64'h2000_0000_0000_0017);
      run_txn("cfg_rd_p2", slot);

      set_base();
      fifo_half = 1'b1;
      enable_piso_upstream = 4'b0001;
      pend_v[N] = 1'b1; pend_d[N] = PW'(64'h2000_0000_0000_0017);
      run_txn("cfg_rd_loc", slot);
      chk("cfg_rd_loc-flags", W'(tx_data[61:60]), 2'b01);

      set_base();
      pend_v[1] = 1'b1; pend_d[1] = PW'(64'h0abc_0000_0000_03fe);
      run_txn("bcast_p1", slot);

      for (int r = 0; r < 3; r++) begin
         set_base();
         enable_piso_upstream = 4'b0001;
         tx_busy = 4'b0001;
         rel_at = (r == 0) ? 0 : TO + r - 1;
         pend_v[N] = 1'b1; pend_d[N] = PW'(64'h5a5a_0000);
         run_txn("timeout", slot);
      end

      for (int i = 0; i < 20; i++) begin
         set_base();
         enable_piso_upstream = '0;
         pend_v[N] = 1'b1; pend_d[N] = PW'(64'h100);
         run_txn("sat", slot);
      end

      for (int i = 0; i < 300; i++) begin
         randomize_stim();
         run_txn("rnd", slot);
      end

      set_base();
      tx_busy = '1;
      enable_piso_upstream = 4'b0001;
      pend_v[N] = 1'b1; pend_d[N] = PW'(64'h77);
      drive_src();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstw-out", W'({rx_ack, local_ack, tx_load, cfg_valid}), '0);
      chk("rstw-txd", tx_data, '0);
      chk("rstw-cfgd", W'(cfg_data), '0);
      chk("rstw-drops", W'(drop_count), '0);
      for (int s = 0; s < NS; s++) pend_v[s] = 1'b0;
      drive_src();
      rr = 0; drops = 0; last_ok = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int s = 0; s < NS; s++) begin
         pend_v[s] = 1'b1;
         pend_d[s] = mk_pkt();
      end
      for (int i = 0; i < 6; i++) begin
         set_base();
         run_txn("rr", slot);
         chk("rr-order", W'(slot), W'(order[i]));
         if (slot >= 0) begin
            pend_v[slot] = 1'b1;
            pend_d[slot] = mk_pkt();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
